reaction_core: RTL
==================

REACTION_CORE -- requirements
Module: reaction_core

Interface
REQ-001 SHALL have parameter MIN_DELAY_MS, default 1000, which sets the minimum random wait in ms before the LED lights.
REQ-002 SHALL have parameter RAND_MASK, default 2047, which is ANDed with the LFSR to give the extra wait in ms (all-ones mask, below 2^16).
REQ-003 SHALL have ports in this order:
- board_clk  in  1  single system clock, 50 MHz.
- rst_n  in  1  asynchronous reset, active low.
- ms_tick  in  1  one-board_clk-wide strobe at 1 kHz from the clock divider.
- start  in  1  synchronized, one-cycle start pulse.
- stop  in  1  synchronized, one-cycle reaction-button pulse.
- led  out  1  stimulus LED, high while ARMED.
- busy  out  1  high in WAIT or ARMED.
- result_bcd  out  16  four BCD digits of reaction time in ms, MSD at [15:12].
- result_valid  out  1  high while in DONE.
- early  out  1  false start flag, high while in FAULT.
- timeout  out  1  high in DONE when the count saturated at 9999.

Function
REQ-004 SHALL implement states IDLE, WAIT, ARMED, DONE, FAULT; all outputs are registered.
REQ-005 SHALL run a free 16-bit Fibonacci LFSR every board_clk (taps 16,14,13,11); it never holds zero.
REQ-006 SHALL act on start only in IDLE, DONE or FAULT, with these effects:
- latch delay = MIN_DELAY_MS + (lfsr & RAND_MASK);
- clear the BCD count, result_valid, early and timeout;
- go to WAIT on the next edge.
REQ-007 SHALL ignore start in WAIT and ARMED.
REQ-008 In WAIT, SHALL decrement the delay on each ms_tick and enter ARMED on the tick that takes it to zero; led rises the cycle after that edge.
REQ-009 In ARMED, SHALL increment the 4-digit BCD count on each ms_tick, with decimal carry between digits.
REQ-010 SHALL handle stop in ARMED as follows:
- freeze the count and go to DONE;
- result_bcd shows the count and result_valid rises the cycle after the stop cycle;
- led falls in that same cycle.
REQ-011 When stop and ms_tick occur in the same cycle in ARMED, stop SHALL win and the count SHALL NOT increment.
REQ-012 When the count reaches 9999 in ARMED, SHALL hold it at 9999, go to DONE with timeout=1, and drop led.
REQ-013 SHALL hold DONE and FAULT, with their outputs, until the next start.
REQ-014 SHALL ignore stop in IDLE, DONE and FAULT.
REQ-015 SHALL keep result_bcd unchanged outside ARMED, except for the clear on start.

Reset
REQ-016 When rst_n is low, SHALL immediately and asynchronously go to IDLE and set all of the following:
- led, busy, result_valid, early, timeout = 0;
- result_bcd = 16'h0000;
- delay counter = 0;
- LFSR = 16'hACE1.
REQ-017 Reset asserted in any state, including mid-WAIT or mid-ARMED, SHALL abort the trial with no result retained.
REQ-018 After rst_n deasserts, SHALL leave IDLE only on a start pulse.

Configuration
REQ-019 Feature macro FALSE_START_DETECT_EN SHALL select false-start handling:
- defined: stop in WAIT goes to FAULT with early=1, busy=0, led=0 and result_bcd=0;
- undefined: stop in WAIT is ignored, FAULT is unreachable, and early is tied to 0.

Structure
REQ-020 Package reaction_pkg SHALL hold:
- the state enum;
- the LFSR seed 16'hACE1 and tap constants;
- the BCD saturation constant 16'h9999.
REQ-021 Sub-module bcd_counter4 SHALL provide the following; all other logic stays in reaction_core:
- inputs: clear, enable;
- outputs: count, saturated (at 9999);
- reset: async active low on rst_n.

Verification
REQ-022 Bench SHALL cover, with MIN_DELAY_MS=3 and RAND_MASK=0, these directed scenarios:
- Basic trial: start, then 3 ticks gives led=1; 250 ticks then stop gives result_bcd=16'h0250, result_valid=1, led=0.
- Tie: stop in the same cycle as the 42nd tick in ARMED gives result_bcd=16'h0041.
- Timeout: 10000 ticks with no stop gives result_bcd=16'h9999, timeout=1, led=0, state DONE.
- False start: stop after 1 tick in WAIT gives early=1 and led never high when FALSE_START_DETECT_EN is defined; when undefined, led=1 after tick 3 and a normal result follows.
- Reset mid-trial: rst_n low for 1 cycle during ARMED at count 0123 gives all outputs 0 immediately; start is then required to leave IDLE.
- Restart: start while in DONE (result 0250) gives result_bcd=0, result_valid=0, busy=1 on the next edge; start while in WAIT is ignored.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time tester.
package reaction_pkg;

  localparam int unsigned LFSR_W  = 16;
  localparam int unsigned BCD_W   = 16;
  localparam int unsigned DELAY_W = 17;

  // Fibonacci taps 16,14,13,11 expressed as bit indices
  localparam int unsigned TAP_16 = 15;
  localparam int unsigned TAP_14 = 13;
  localparam int unsigned TAP_13 = 12;
  localparam int unsigned TAP_11 = 10;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [BCD_W-1:0]  BCD_MAX   = 16'h9999;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ARMED = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  // One shift of the Fibonacci LFSR; a non-zero seed never reaches zero
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    logic fb;
    fb = cur[TAP_16] ^ cur[TAP_14] ^ cur[TAP_13] ^ cur[TAP_11];
    return {cur[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter that holds at 9999 and flags saturation.
module bcd_counter4
  import reaction_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [BCD_W-1:0] count,
  output logic             saturated
);

  logic [BCD_W-1:0] count_q, count_d;
  logic             sat_q;

  // Ripple the decimal carry from the least significant digit upwards
  always_comb begin
    logic       carry;
    logic [3:0] digit;
    count_d = count_q;
    carry   = enable && (count_q != BCD_MAX);
    for (int i = 0; i < 4; i++) begin
      digit = count_q[4*i +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          count_d[4*i +: 4] = 4'd0;
        end else begin
          count_d[4*i +: 4] = digit + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    if (clear) count_d = '0;
  end

  // Count and saturation flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= (count_d == BCD_MAX);
    end
  end

  assign count     = count_q;
  assign saturated = sat_q;

endmodule

// File: rtl/reaction_core.sv
// Reaction-time tester: random wait, LED stimulus, BCD timing of the response.
// Optional false-start detection is enabled by defining FALSE_START_DETECT_EN.
module reaction_core
  import reaction_pkg::*;
#(
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_MASK    = 2047
) (
  input  logic        board_clk,
  input  logic        rst_n,
  input  logic        ms_tick,
  input  logic        start,
  input  logic        stop,
  output logic        led,
  output logic        busy,
  output logic [15:0] result_bcd,
  output logic        result_valid,
  output logic        early,
  output logic        timeout
);

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic                cnt_clear, cnt_en, cnt_sat;
  logic                led_q, busy_q, valid_q, timeout_q;
  logic                timeout_d;

  // Free-running stimulus randomiser
  always_ff @(posedge board_clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_next(lfsr_q);
  end

  // Next-state, delay and counter control
  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start) begin
          delay_d   = DELAY_W'(MIN_DELAY_MS) + DELAY_W'(lfsr_q & LFSR_W'(RAND_MASK));
          cnt_clear = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
`ifdef FALSE_START_DETECT_EN
        if (stop) begin
          cnt_clear = 1'b1;
          state_d   = ST_FAULT;
        end else
`endif
        if (ms_tick) begin
          delay_d = (delay_q == '0) ? '0 : delay_q - DELAY_W'(1);
          if (delay_q <= DELAY_W'(1)) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (stop || cnt_sat) state_d = ST_DONE;
        else if (ms_tick)    cnt_en  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    timeout_d = (state_d == ST_DONE) &&
                (timeout_q || ((state_q == ST_ARMED) && cnt_sat));
  end

  // State, delay and registered status outputs
  always_ff @(posedge board_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      delay_q   <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      led_q     <= (state_d == ST_ARMED);
      busy_q    <= (state_d == ST_WAIT) || (state_d == ST_ARMED);
      valid_q   <= (state_d == ST_DONE);
      timeout_q <= timeout_d;
    end
  end

`ifdef FALSE_START_DETECT_EN
  logic early_q;

  // False-start flag follows the FAULT state
  always_ff @(posedge board_clk or negedge rst_n) begin
    if (!rst_n) early_q <= 1'b0;
    else        early_q <= (state_d == ST_FAULT);
  end

  assign early = early_q;
`else
  assign early = 1'b0;
`endif

  bcd_counter4 u_bcd_counter4 (
    .clk       (board_clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .enable    (cnt_en),
    .count     (result_bcd),
    .saturated (cnt_sat)
  );

  assign led          = led_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign timeout      = timeout_q;

endmodule
